display7_scan: RTL and testbench

- Time-multiplexed driver for an N-digit common-anode 7-segment display.
- Takes a packed vector of 4-bit codes and drives one digit per scan slot, with one-hot active-low anode select and active-low segments.
- Adds tear-free frame-boundary update, leading-zero suppression, per-digit blink, decimal points and an anti-ghosting guard gap.
- Sits between the piano note/score logic and the board display pins.

---
 rtl/display7_scan.sv | 176 +++++++++++++++++
 tb/tb_display7_scan.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/display7_scan.sv
// display7_scan: time-multiplexed common-anode 7-segment driver.
// One digit is lit per scan slot; new data is only adopted at the frame
// boundary so a frame never shows a mix of old and new values.
module display7_scan #(
   parameter int NUM_DIGITS   = 8,
   parameter int SCAN_DIV     = 100000,
   parameter int GUARD        = 16,
   parameter int BLINK_FRAMES = 250
) (
   input  logic                    iClk,
   input  logic                    iRst_n,
   input  logic                    iLoad,
   input  logic [4*NUM_DIGITS-1:0] iDigits,
   input  logic [NUM_DIGITS-1:0]   iDp,
   input  logic [NUM_DIGITS-1:0]   iBlinkMask,
   input  logic                    iLzs,
   output logic [NUM_DIGITS-1:0]   oAn,
   output logic [6:0]              oLed,
   output logic                    oDp,
   output logic                    oFrame
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int BLK_W = $clog2(BLINK_FRAMES + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DIV_W-1:0] GUARD_C  = DIV_W'(GUARD);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

   // Active-low segment pattern {g,f,e,d,c,b,a}; 10..12 are bar glyphs.
   function automatic logic [6:0] seg7(input logic [3:0] code);
      case (code)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         4'd10:   seg7 = 7'b1110111;
         4'd11:   seg7 = 7'b0111111;
         4'd12:   seg7 = 7'b1111110;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   logic [DIV_W-1:0]        div_q, div_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [BLK_W-1:0]        bcnt_q, bcnt_d;
   logic                    bphase_q, bphase_d;
   logic                    wrap;

   logic [4*NUM_DIGITS-1:0] shd_dig_q, dsp_dig_q;
   logic [NUM_DIGITS-1:0]   shd_dp_q, dsp_dp_q;
   logic [NUM_DIGITS-1:0]   shd_bm_q, dsp_bm_q;

   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [6:0]              led_q, led_d;
   logic                    dp_q, dp_d;
   logic                    frame_q;

   // Per-digit view of the display codes plus leading-zero analysis.
   // sig[k] is set when any digit at or above k holds a visible glyph (1..12).
   logic [3:0]              dig_arr [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   sig;
   logic [NUM_DIGITS-1:0]   supp;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         logic vis;
         assign dig_arr[gi] = dsp_dig_q[4*gi +: 4];
         assign vis = (dig_arr[gi] >= 4'd1) && (dig_arr[gi] <= 4'd12);
         if (gi == NUM_DIGITS - 1) begin : g_top
            assign sig[gi] = vis;
         end else begin : g_mid
            assign sig[gi] = vis | sig[gi+1];
         end
         if (gi == 0) begin : g_lsd
            assign supp[gi] = 1'b0;
         end else begin : g_upper
            assign supp[gi] = iLzs & ~sig[gi];
         end
      end
   endgenerate

   // Scan divider, digit index and blink phase next-state.
   always_comb begin
      div_d    = div_q + DIV_W'(1);
      idx_d    = idx_q;
      bcnt_d   = bcnt_q;
      bphase_d = bphase_q;
      wrap     = 1'b0;
      if (div_q == DIV_LAST) begin
         div_d = '0;
         if (idx_q == IDX_LAST) begin
            idx_d = '0;
            wrap  = 1'b1;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
      if (wrap) begin
         if (bcnt_q == BLK_LAST) begin
            bcnt_d   = '0;
            bphase_d = ~bphase_q;
         end else begin
            bcnt_d = bcnt_q + BLK_W'(1);
         end
      end
   end

   // Output pattern for the slot currently addressed by div/index.
   always_comb begin
      logic blank;
      blank = supp[idx_q] | (bphase_q & dsp_bm_q[idx_q]);
      an_d  = '1;
      if (div_q >= GUARD_C) begin
         an_d[idx_q] = 1'b0;
      end
      led_d = blank ? 7'h7F : seg7(dig_arr[idx_q]);
      dp_d  = blank ? 1'b1 : ~dsp_dp_q[idx_q];
   end

   // State, shadow/display data and registered outputs.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         div_q     <= '0;
         idx_q     <= '0;
         bcnt_q    <= '0;
         bphase_q  <= 1'b0;
         shd_dig_q <= '1;
         shd_dp_q  <= '0;
         shd_bm_q  <= '0;
         dsp_dig_q <= '1;
         dsp_dp_q  <= '0;
         dsp_bm_q  <= '0;
         an_q      <= '1;
         led_q     <= 7'h7F;
         dp_q      <= 1'b1;
         frame_q   <= 1'b0;
      end else begin
         div_q    <= div_d;
         idx_q    <= idx_d;
         bcnt_q   <= bcnt_d;
         bphase_q <= bphase_d;
         if (iLoad) begin
            shd_dig_q <= iDigits;
            shd_dp_q  <= iDp;
            shd_bm_q  <= iBlinkMask;
         end
         // Display takes the shadow as it was before this edge, so a load
         // coincident with the boundary waits for the next frame.
         if (wrap) begin
            dsp_dig_q <= shd_dig_q;
            dsp_dp_q  <= shd_dp_q;
            dsp_bm_q  <= shd_bm_q;
         end
         an_q    <= an_d;
         led_q   <= led_d;
         dp_q    <= dp_d;
         frame_q <= wrap;
      end
   end

   assign oAn    = an_q;
   assign oLed   = led_q;
   assign oDp    = dp_q;
   assign oFrame = frame_q;

endmodule

// File: tb/tb_display7_scan.sv
// Scoreboard bench for display7_scan: per-frame expected digit slots are
// queued at each frame start and popped as the DUT lights each digit.
module tb_display7_scan;

   localparam int N  = 4;
   localparam int SD = 4;
   localparam int GD = 1;
   localparam int BF = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           load = 1'b0;
   logic [4*N-1:0] digits = '0;
   logic [N-1:0]   dp_in = '0;
   logic [N-1:0]   bm_in = '0;
   logic           lzs = 1'b0;
   logic [N-1:0]   an;
   logic [6:0]     led;
   logic           dp;
   logic           frame;

   int vectors = 0;
   int miscompares = 0;

   // Model of shadow and displayed data, and frames since reset.
   logic [15:0] shd_m = 16'hFFFF, dsp_m = 16'hFFFF;
   logic [3:0]  shd_dp_m = '0, dsp_dp_m = '0;
   logic [3:0]  shd_bm_m = '0, dsp_bm_m = '0;
   int          fcnt = 0;

   // Entry: {an[3:0], led[6:0], dp}
   logic [11:0] sb_q [$];

   display7_scan #(
      .NUM_DIGITS(N), .SCAN_DIV(SD), .GUARD(GD), .BLINK_FRAMES(BF)
   ) dut (
      .iClk(clk), .iRst_n(rst_n), .iLoad(load), .iDigits(digits),
      .iDp(dp_in), .iBlinkMask(bm_in), .iLzs(lzs),
      .oAn(an), .oLed(led), .oDp(dp), .oFrame(frame)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg_ref(input logic [3:0] c);
      logic [6:0] t [16];
      t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b1110111, 7'b0111111,
            7'b1111110, 7'b1111111, 7'b1111111, 7'b1111111};
      return t[c];
   endfunction

   // Queue the four slots of the frame numbered f.
   task automatic push_frame(input int f);
      logic       lead;
      logic [3:0] c;
      logic [3:0] sup;
      logic       phase;
      logic       blank;
      logic [3:0] an_e;
      lead  = 1'b1;
      sup   = '0;
      phase = ((f / BF) % 2) == 1;
      for (int k = N - 1; k >= 0; k--) begin
         c = dsp_m[4*k +: 4];
         if (lzs && lead && k != 0 && (c == 4'd0 || c >= 4'd13)) sup[k] = 1'b1;
         else if (c >= 4'd1 && c <= 4'd12) lead = 1'b0;
      end
      for (int k = 0; k < N; k++) begin
         blank = sup[k] | (phase & dsp_bm_m[k]);
         an_e  = 4'hF;
         an_e[k] = 1'b0;
         sb_q.push_back({an_e, blank ? 7'h7F : seg_ref(dsp_m[4*k +: 4]),
                         blank ? 1'b1 : ~dsp_dp_m[k]});
      end
   endtask

   task automatic wait_frame();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame && n < 40);
      check("frame_timeout", frame, 1);
   endtask

   task automatic frame_begin();
      dsp_m    = shd_m;
      dsp_dp_m = shd_dp_m;
      dsp_bm_m = shd_bm_m;
      fcnt++;
      push_frame(fcnt);
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
      load = 1'b1; digits = d; dp_in = p; bm_in = b;
      shd_m = d; shd_dp_m = p; shd_bm_m = b;
      @(negedge clk);
      load = 1'b0;
   endtask

   // Monitor: pops one expectation at each slot start and checks timing.
   initial begin
      logic [3:0]  prev_an = 4'hF;
      logic [11:0] e;
      int run = 0, gap = 0;
      bit have_frame = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_an = 4'hF; run = 0; gap = 0; have_frame = 0;
         end else begin
            gap++;
            if (frame) begin
               if (have_frame) check("frame_gap", gap, SD * N);
               have_frame = 1; gap = 0;
            end
            check("an_onehot", ($countones(~an) <= 1), 1);
            if (an != 4'hF) begin
               if (prev_an == 4'hF) begin
                  if (sb_q.size() == 0) begin
                     check("sb_underflow", 1, 0);
                  end else begin
                     e = sb_q.pop_front();
                     check("an", an, e[11:8]);
                     check("led", led, e[7:1]);
                     check("dp", dp, e[0]);
                     $display("slot an=%b led=%b dp=%b (exp %b %b %b)",
                              an, led, dp, e[11:8], e[7:1], e[0]);
                  end
               end
               run++;
            end else if (prev_an != 4'hF) begin
               check("slot_len", run, SD - GD);
               run = 0;
            end
            prev_an = an;
         end
      end
   end

   // Driver
   initial begin
      logic [15:0] nd;
      int n;
      repeat (2) @(negedge clk);
      check("rst_an", an, 4'hF);
      check("rst_led", led, 7'h7F);
      check("rst_dp", dp, 1);
      check("rst_frame", frame, 0);
      rst_n = 1'b1;
      fcnt = 0;
      push_frame(0);

      // Blank frame, then 1290 loaded mid-frame (old data stays this frame).
      wait_frame(); frame_begin();
      repeat (5) @(negedge clk);
      do_load(16'h1290, 4'b0100, 4'b0000);
      wait_frame(); frame_begin();
      wait_frame(); frame_begin();

      // Leading-zero suppression patterns.
      do_load(16'h0070, 4'b0000, 4'b0000);
      wait_frame(); lzs = 1'b1; frame_begin();
      repeat (4) @(negedge clk);
      do_load(16'h0000, 4'b0000, 4'b0000);
      wait_frame(); frame_begin();
      repeat (4) @(negedge clk);
      do_load(16'hB000, 4'b0000, 4'b0000);
      wait_frame(); frame_begin();

      // Blink on digit 0.
      repeat (4) @(negedge clk);
      do_load(16'h1234, 4'b0000, 4'b0001);
      wait_frame(); lzs = 1'b0; frame_begin();
      for (int i = 0; i < 5; i++) begin
         wait_frame(); frame_begin();
      end

      // Two loads in one frame, then a load on the boundary cycle.
      repeat (4) @(negedge clk);
      do_load(16'h1111, 4'b0000, 4'b0000);
      repeat (3) @(negedge clk);
      do_load(16'h2222, 4'b0000, 4'b0000);
      wait_frame(); frame_begin();
      repeat (15) @(negedge clk);
      nd = 16'h3333;
      load = 1'b1; digits = nd; dp_in = '0; bm_in = '0;
      @(negedge clk);
      load = 1'b0;
      check("coinc_frame", frame, 1);
      frame_begin();
      shd_m = nd; shd_dp_m = '0; shd_bm_m = '0;
      wait_frame(); frame_begin();

      // Reset in the middle of digit 2's slot.
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (an != 4'b1011 && n < 40);
      check("wait_dig2", an, 4'b1011);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_an", an, 4'hF);
      check("mid_rst_led", led, 7'h7F);
      check("mid_rst_dp", dp, 1);
      check("mid_rst_frame", frame, 0);
      sb_q.delete();
      shd_m = 16'hFFFF; dsp_m = 16'hFFFF;
      shd_dp_m = '0; dsp_dp_m = '0; shd_bm_m = '0; dsp_bm_m = '0;
      fcnt = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      push_frame(0);
      wait_frame(); frame_begin();

      n = 0;
      while (sb_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("sb_drain", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
